// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: FSM states, stall vector width, stall codes and multi-cycle length default
package pipe_ctrl_pkg;
  typedef enum logic {RUN, MC} state_t;
  localparam int STALL_W = 6;
  localparam int MC_LEN_W = 6;
  localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
  localparam logic [STALL_W-1:0] STALL_ID = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX = 6'b001111;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stall/flush request and response bundle between pipeline stages and pipe_ctrl
interface pipe_ctrl_if #(parameter int MC_LEN_W = 6, parameter int STALL_W = 6);
  logic stallreq_id;
  logic stallreq_ex;
  logic ex_mc_start;
  logic [MC_LEN_W-1:0] ex_mc_len;
  logic flush_req;
  logic [31:0] flush_pc;
  logic [STALL_W-1:0] stall;
  logic flush;
  logic [31:0] new_pc;
  logic ex_mc_done;
  logic busy;
  logic [31:0] stall_cycles;
  modport master (
    output stallreq_id, stallreq_ex, ex_mc_start, ex_mc_len, flush_req, flush_pc,
    input stall, flush, new_pc, ex_mc_done, busy, stall_cycles
  );
  modport slave (
    input stallreq_id, stallreq_ex, ex_mc_start, ex_mc_len, flush_req, flush_pc,
    output stall, flush, new_pc, ex_mc_done, busy, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl_stall_perf_cnt.sv
// stall_perf_cnt: saturating 32-bit count of enabled cycles
module stall_perf_cnt (
  input logic clk,
  input logic rst,
  input logic en,
  output logic [31:0] count
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (en && count != '1) count <= count + 32'd1;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush arbiter with multi-cycle EX sequencing.
// Define STALL_PERF_CNT_EN to enable the stall_cycles performance counter.
module pipe_ctrl #(
  parameter int MC_LEN_W = pipe_ctrl_pkg::MC_LEN_W,
  parameter int STALL_W = pipe_ctrl_pkg::STALL_W
) (
  input logic clk,
  input logic rst,
  pipe_ctrl_if.slave bus
);
  import pipe_ctrl_pkg::*;
  state_t state, state_nx;
  logic [MC_LEN_W-1:0] cnt, cnt_nx;
  logic mc_go, mc_busy, mc_fin, ex_win;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  // Outputs are gated by rst so they read zero while reset is held, whatever the inputs.
  always_comb begin
    mc_go = state == RUN && bus.ex_mc_start && bus.ex_mc_len != '0;
    mc_busy = state == MC && cnt != '0;
    mc_fin = state == MC && cnt == '0;
    ex_win = bus.stallreq_ex || mc_go || mc_busy;
    bus.flush = rst && bus.flush_req;
    bus.new_pc = bus.flush ? bus.flush_pc : 32'd0;
    bus.ex_mc_done = rst && !bus.flush_req && mc_fin;
    bus.stall = (!rst || bus.flush_req) ? STALL_W'(STALL_NONE)
              : ex_win ? STALL_W'(STALL_EX)
              : bus.stallreq_id ? STALL_W'(STALL_ID) : STALL_W'(STALL_NONE);
    bus.busy = state != RUN;
    state_nx = bus.flush_req ? RUN : mc_go ? MC : mc_fin ? RUN : state;
    cnt_nx = bus.flush_req ? '0 : mc_go ? bus.ex_mc_len - 1'b1 : mc_busy ? cnt - 1'b1 : cnt;
  end
`ifdef STALL_PERF_CNT_EN
  stall_perf_cnt u_perf (
    .clk(clk),
    .rst(rst),
    .en(|bus.stall),
    .count(bus.stall_cycles)
  );
`else
  assign bus.stall_cycles = 32'd0;
`endif
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- MC_LEN_W, 6, width of the multi-cycle length field.
- STALL_W, 6, stall vector width: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_id  in  1  level request from decode to stall (load-use).
- stallreq_ex  in  1  level request from execute to stall (external busy).
- ex_mc_start  in  1  execute begins a multi-cycle operation this cycle.
- ex_mc_len  in  MC_LEN_W  length of that operation in cycles; 0 means none.
- flush_req  in  1  exception or redirect request.
- flush_pc  in  32  redirect target.
- stall  out  STALL_W  per-stage hold vector.
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  32  redirect target, valid when flush=1.
- ex_mc_done  out  1  multi-cycle result valid in EX this cycle.
- busy  out  1  FSM not in RUN.
- stall_cycles  out  32  stall performance count (see Configuration).

Function
REQ-003 The FSM SHALL have states RUN, MC, encoded in the shared package.
REQ-004 stall, flush, new_pc and ex_mc_done SHALL be combinational from the current state, the counter and the inputs, so a request takes effect in the same cycle.
REQ-005 Request priority SHALL be: flush_req, then EX (stallreq_ex, MC counting or an accepted ex_mc_start), then stallreq_id.
REQ-006 Output encoding by winning request:
- flush: stall=6'b000000, flush=1, new_pc=flush_pc.
- EX: stall=6'b001111.
- ID only: stall=6'b000111.
- none: stall=0.
- new_pc SHALL be 0 whenever flush=0.
REQ-007 In RUN, an ex_mc_start with ex_mc_len=L>=1 and no flush_req SHALL:
- assert the EX stall code in that cycle;
- load a counter with L-1;
- go to MC.
REQ-008 In MC with counter != 0, the block SHALL assert the EX stall code and decrement the counter each edge.
REQ-009 In MC with counter == 0, the block SHALL:
- deassert the MC contribution to stall;
- pulse ex_mc_done=1 for exactly one cycle;
- return to RUN.
- Net effect: L stalled cycles, then done in cycle T+L.
REQ-010 An ex_mc_start with ex_mc_len=0 SHALL be ignored: no stall and no ex_mc_done.
REQ-011 An ex_mc_start received while in MC SHALL be ignored.
REQ-012 A flush_req in MC SHALL abort the operation:
- flush=1 in that cycle;
- counter cleared;
- next state RUN;
- no ex_mc_done.
REQ-013 When flush_req and ex_mc_start occur together in RUN, flush SHALL win and the operation SHALL NOT start.
REQ-014 stallreq_ex SHALL be ORed with the MC contribution; ex_mc_done SHALL still pulse on schedule while stallreq_ex holds.
REQ-015 busy SHALL equal (state != RUN).

Reset
REQ-016 While rst=0 the block SHALL hold state=RUN, counter=0 and stall_cycles=0, and SHALL drive stall=0, flush=0, new_pc=0, ex_mc_done=0 and busy=0 regardless of the inputs.
REQ-017 A reset asserted during MC SHALL abandon the operation with no ex_mc_done after release.

Configuration
REQ-018 With macro STALL_PERF_CNT_EN defined, stall_cycles SHALL increment by 1 on every edge where stall != 0, saturating at 32'hFFFF_FFFF.
REQ-019 Without STALL_PERF_CNT_EN, stall_cycles SHALL be constant 0 and no counter register SHALL be synthesized.

Structure
REQ-020 The shared package SHALL hold:
- the FSM state encoding;
- STALL_W;
- the stall codes STALL_NONE, STALL_ID and STALL_EX;
- the MC_LEN_W default.
REQ-021 The saturating counter SHALL be the sub-module stall_perf_cnt, instantiated only under STALL_PERF_CNT_EN; everything else SHALL be flat.

Verification
REQ-022 The bench SHALL cover these directed scenarios (stimulus -> required response):
- stallreq_id=1 for 2 cycles -> stall=6'b000111 in both cycles, then 0; flush=0 throughout.
- ex_mc_start with ex_mc_len=4 at cycle T -> stall=6'b001111 in T..T+3; ex_mc_done=1 only in T+4; busy=1 in T+1..T+4.
- ex_mc_len=3 at T, flush_req with flush_pc=32'h0000_0100 at T+1 -> flush=1 and new_pc=32'h100 at T+1; stall=0 at T+1; no ex_mc_done; busy=0 at T+2.
- ex_mc_start with ex_mc_len=2 plus flush_req in the same cycle -> flush=1, no stall, busy stays 0.
- ex_mc_len=0 -> no stall; ex_mc_len=1 at T -> stall in T only, ex_mc_done in T+1.
- STALL_PERF_CNT_EN defined, 5 stalled cycles after reset -> stall_cycles=5; rst pulsed low mid-sequence -> stall_cycles=0 and all outputs 0 immediately (asynchronously).
